// File: rtl/drp_reg_bank_pkg.sv
// Shared definitions for the DRP register bank: FSM states, address map,
// register field positions and the address decoder.
package drp_reg_bank_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_ACK
    } state_t;

    typedef enum logic [2:0] {
        RK_NONE,
        RK_CH,
        RK_FB,
        RK_DIV,
        RK_LOCK,
        RK_PWR,
        RK_FILT
    } reg_kind_t;

    // Decoded register selection: kind, channel/sub-index and Reg1/Reg2 choice.
    typedef struct packed {
        reg_kind_t  kind;
        logic [2:0] idx;
        logic       second;
    } reg_sel_t;

    localparam logic [6:0] ADDR_CH5_R1  = 7'h06;
    localparam logic [6:0] ADDR_CH5_R2  = 7'h07;
    localparam logic [6:0] ADDR_CH0_R1  = 7'h08;
    localparam logic [6:0] ADDR_CH4_R2  = 7'h11;
    localparam logic [6:0] ADDR_CH6_R1  = 7'h12;
    localparam logic [6:0] ADDR_CH6_R2  = 7'h13;
    localparam logic [6:0] ADDR_FB_R1   = 7'h14;
    localparam logic [6:0] ADDR_FB_R2   = 7'h15;
    localparam logic [6:0] ADDR_DIV     = 7'h16;
    localparam logic [6:0] ADDR_LOCK1   = 7'h18;
    localparam logic [6:0] ADDR_LOCK3   = 7'h1A;
    localparam logic [6:0] ADDR_POWER   = 7'h28;
    localparam logic [6:0] ADDR_FILT1   = 7'h4E;
    localparam logic [6:0] ADDR_FILT2   = 7'h4F;

    // Reg1 fields
    localparam int unsigned PM_HI    = 15;
    localparam int unsigned PM_LO    = 13;
    localparam int unsigned H_HI     = 11;
    localparam int unsigned H_LO     = 6;
    localparam int unsigned L_HI     = 5;
    localparam int unsigned L_LO     = 0;
    localparam int unsigned DIV_BYP  = 12;
    // Reg2 fields
    localparam int unsigned MX_HI    = 9;
    localparam int unsigned MX_LO    = 8;
    localparam int unsigned EDGE_BIT = 7;
    localparam int unsigned NOCNT    = 6;
    localparam int unsigned DT_HI    = 5;
    localparam int unsigned DT_LO    = 0;

    // Decode-target codes beyond the channel indices 0..6
    localparam logic [3:0] DEC_FB  = 4'd7;
    localparam logic [3:0] DEC_DIV = 4'd8;

    localparam logic [31:0] DIVIDE_RST = 32'd1;
    localparam logic [31:0] DUTY_RST   = 32'd500;
    localparam logic [31:0] MULT_RST   = 32'd1000;

    // A 6-bit high/low count of zero means 64.
    function automatic logic [6:0] field_count(input logic [5:0] f);
        return (f == 6'd0) ? 7'd64 : {1'b0, f};
    endfunction

    function automatic reg_sel_t decode_addr(input logic [6:0] a);
        reg_sel_t s;
        s = '{kind: RK_NONE, idx: 3'd0, second: 1'b0};
        if (a == ADDR_CH5_R1 || a == ADDR_CH5_R2) begin
            s = '{kind: RK_CH, idx: 3'd5, second: a[0]};
        end else if (a inside {[ADDR_CH0_R1:ADDR_CH4_R2]}) begin
            s = '{kind: RK_CH, idx: 3'((a - ADDR_CH0_R1) >> 1), second: a[0]};
        end else if (a == ADDR_CH6_R1 || a == ADDR_CH6_R2) begin
            s = '{kind: RK_CH, idx: 3'd6, second: a[0]};
        end else if (a == ADDR_FB_R1 || a == ADDR_FB_R2) begin
            s = '{kind: RK_FB, idx: 3'd0, second: a[0]};
        end else if (a == ADDR_DIV) begin
            s = '{kind: RK_DIV, idx: 3'd0, second: 1'b0};
        end else if (a inside {[ADDR_LOCK1:ADDR_LOCK3]}) begin
            s = '{kind: RK_LOCK, idx: 3'(a - ADDR_LOCK1), second: 1'b0};
        end else if (a == ADDR_POWER) begin
            s = '{kind: RK_PWR, idx: 3'd0, second: 1'b0};
        end else if (a == ADDR_FILT1 || a == ADDR_FILT2) begin
            s = '{kind: RK_FILT, idx: {2'b00, a[0]}, second: 1'b0};
        end
        return s;
    endfunction

endpackage

// File: rtl/drp_reg_bank_clk_decode.sv
// Combinational decode of one Reg1/Reg2 pair plus VCO period into
// divide, duty (x1000) and phase delay (time x1000).
module drp_clk_decode
    import drp_reg_bank_pkg::*;
(
    input  logic [15:0] reg1,
    input  logic [15:0] reg2,
    input  logic [31:0] vco_period_1000,
    output logic [31:0] divide,
    output logic [31:0] duty,
    output logic [31:0] phase,
    output logic        mx_err
);

    logic [6:0]  high;
    logic [6:0]  low;
    logic [31:0] count_sum;
    logic [31:0] duty_num;
    logic [31:0] pm_term;
    logic [31:0] dt_term;
    logic        unused_bits;

    // Field extraction and fixed-point arithmetic for one channel.
    always_comb begin
        high      = field_count(reg1[H_HI:H_LO]);
        low       = field_count(reg1[L_HI:L_LO]);
        count_sum = 32'(high) + 32'(low);
        duty_num  = (32'(high) * 32'd2 + 32'(reg2[EDGE_BIT])) * 32'd500;
        pm_term   = (vco_period_1000 * 32'(reg1[PM_HI:PM_LO])) / 32'd8;
        dt_term   = vco_period_1000 * 32'(reg2[DT_HI:DT_LO]);
        phase     = pm_term + dt_term;
        mx_err    = |reg2[MX_HI:MX_LO];
        if (reg2[NOCNT]) begin
            divide = DIVIDE_RST;
            duty   = DUTY_RST;
        end else begin
            divide = count_sum;
            duty   = duty_num / count_sum;
        end
    end

    assign unused_bits = ^{reg1[DIV_BYP], reg2[15:10]};

endmodule

// File: rtl/drp_reg_bank.sv
// DRP register bank with DRDY handshake, error reporting and decoded
// divide/duty/phase outputs for the behavioural PLL/MMCM clock generators.
module drp_reg_bank
    import drp_reg_bank_pkg::*;
#(
    parameter int unsigned NUM_CLKOUT   = 7,
    parameter int unsigned DRDY_LATENCY = 3,
    parameter logic [15:0] PWR_RST_VAL  = 16'h1111
) (
    input  logic                    DCLK,
    input  logic                    RST,
    input  logic                    PWRDWN,
    input  logic [6:0]              DADDR,
    input  logic                    DEN,
    input  logic                    DWE,
    input  logic [15:0]             DI,
    input  logic [31:0]             vco_period_1000,
    output logic [15:0]             DO,
    output logic                    DRDY,
    output logic                    ERR,
    output logic [32*NUM_CLKOUT-1:0] CLKOUT_DIVIDE,
    output logic [32*NUM_CLKOUT-1:0] CLKOUT_DUTY_1000,
    output logic [32*NUM_CLKOUT-1:0] CLKOUT_PHASE_1000,
    output logic [31:0]             CLKFBOUT_MULT_1000,
    output logic [31:0]             CLKFBOUT_PHASE_1000,
    output logic [31:0]             DIVCLK_DIVIDE
);

    localparam logic [3:0] CNT_LAST = 4'(DRDY_LATENCY - 1);

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt;
    logic        accept;
    reg_sel_t    sel_in;
    logic        valid_in;
    reg_sel_t    acc_sel;
    logic        acc_valid;
    logic        acc_we;
    logic [15:0] read_data;
    logic        dec_pending;
    logic [3:0]  dec_sel;
    logic        decode_mx;
    logic        err_set;

    logic [15:0] clk_reg1 [NUM_CLKOUT];
    logic [15:0] clk_reg2 [NUM_CLKOUT];
    logic [15:0] fb_reg1;
    logic [15:0] fb_reg2;
    logic [15:0] div_reg;
    logic [15:0] lock_reg [3];
    logic [15:0] power_reg;
    logic [15:0] filt_reg [2];

    logic [31:0] dec_divide [NUM_CLKOUT];
    logic [31:0] dec_duty   [NUM_CLKOUT];
    logic [31:0] dec_phase  [NUM_CLKOUT];
    logic        dec_mx     [NUM_CLKOUT];
    logic [31:0] fb_divide;
    logic [31:0] unused_fb_duty;
    logic [31:0] fb_phase;
    logic        fb_mx;

    logic [31:0] out_divide [NUM_CLKOUT];
    logic [31:0] out_duty   [NUM_CLKOUT];
    logic [31:0] out_phase  [NUM_CLKOUT];
    logic [31:0] out_mult;
    logic [31:0] out_fb_phase;
    logic [31:0] out_divclk;

    function automatic logic sel_valid(input reg_sel_t s);
        return (s.kind != RK_NONE) &&
               !(s.kind == RK_CH && 32'(s.idx) >= NUM_CLKOUT);
    endfunction

    assign sel_in   = decode_addr(DADDR);
    assign valid_in = sel_valid(sel_in);
    assign accept   = DEN && !PWRDWN && (state == ST_IDLE || state == ST_ACK);

    // FSM state register.
    always_ff @(posedge DCLK or posedge RST) begin
        if (RST) state <= ST_IDLE;
        else     state <= state_next;
    end

    // FSM next state: PWRDWN aborts a busy access without DRDY.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: if (accept) state_next = ST_BUSY;
            ST_BUSY: begin
                if (PWRDWN)                state_next = ST_IDLE;
                else if (cnt == CNT_LAST)  state_next = ST_ACK;
            end
            ST_ACK:  state_next = accept ? ST_BUSY : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: DRDY is high for the single ACK cycle.
    always_comb begin
        DRDY = (state == ST_ACK);
    end

    // Latency counter, restarted on every accepted access.
    always_ff @(posedge DCLK or posedge RST) begin
        if (RST)                   cnt <= '0;
        else if (accept)           cnt <= 4'd1;
        else if (state == ST_BUSY) cnt <= cnt + 4'd1;
    end

    // Capture the accepted access for the later read-data load.
    always_ff @(posedge DCLK or posedge RST) begin
        if (RST) begin
            acc_sel   <= '{kind: RK_NONE, idx: 3'd0, second: 1'b0};
            acc_valid <= 1'b0;
            acc_we    <= 1'b0;
        end else if (accept) begin
            acc_sel   <= sel_in;
            acc_valid <= valid_in;
            acc_we    <= DWE;
        end
    end

    // Register writes happen at the accepting edge; invalid targets are dropped.
    always_ff @(posedge DCLK or posedge RST) begin
        if (RST) begin
            clk_reg1  <= '{default: '0};
            clk_reg2  <= '{default: '0};
            fb_reg1   <= '0;
            fb_reg2   <= '0;
            div_reg   <= '0;
            lock_reg  <= '{default: '0};
            power_reg <= PWR_RST_VAL;
            filt_reg  <= '{default: '0};
        end else if (accept && DWE && valid_in) begin
            case (sel_in.kind)
                RK_CH: begin
                    for (int unsigned k = 0; k < NUM_CLKOUT; k++) begin
                        if (32'(sel_in.idx) == k) begin
                            if (sel_in.second) clk_reg2[k] <= DI;
                            else               clk_reg1[k] <= DI;
                        end
                    end
                end
                RK_FB: begin
                    if (sel_in.second) fb_reg2 <= DI;
                    else               fb_reg1 <= DI;
                end
                RK_DIV: div_reg <= DI;
                RK_LOCK: begin
                    for (int unsigned k = 0; k < 3; k++) begin
                        if (32'(sel_in.idx) == k) lock_reg[k] <= DI;
                    end
                end
                RK_PWR:  power_reg <= DI;
                RK_FILT: filt_reg[sel_in.idx[0]] <= DI;
                default: ;
            endcase
        end
    end

    // Decode strobe one edge after a write to a channel, FB or Div register;
    // independent of the FSM so an aborted write still gets decoded.
    always_ff @(posedge DCLK or posedge RST) begin
        if (RST) begin
            dec_pending <= 1'b0;
            dec_sel     <= '0;
        end else begin
            dec_pending <= accept && DWE && valid_in &&
                           (sel_in.kind inside {RK_CH, RK_FB, RK_DIV});
            dec_sel     <= (sel_in.kind == RK_CH) ? {1'b0, sel_in.idx} :
                           (sel_in.kind == RK_FB) ? DEC_FB : DEC_DIV;
        end
    end

    for (genvar k = 0; k < NUM_CLKOUT; k++) begin : g_ch
        drp_clk_decode u_dec (
            .reg1            (clk_reg1[k]),
            .reg2            (clk_reg2[k]),
            .vco_period_1000 (vco_period_1000),
            .divide          (dec_divide[k]),
            .duty            (dec_duty[k]),
            .phase           (dec_phase[k]),
            .mx_err          (dec_mx[k])
        );
        assign CLKOUT_DIVIDE[32*k +: 32]     = out_divide[k];
        assign CLKOUT_DUTY_1000[32*k +: 32]  = out_duty[k];
        assign CLKOUT_PHASE_1000[32*k +: 32] = out_phase[k];
    end

    drp_clk_decode u_fb_dec (
        .reg1            (fb_reg1),
        .reg2            (fb_reg2),
        .vco_period_1000 (vco_period_1000),
        .divide          (fb_divide),
        .duty            (unused_fb_duty),
        .phase           (fb_phase),
        .mx_err          (fb_mx)
    );

    // MX flag of whichever register pair is being decoded.
    always_comb begin
        decode_mx = 1'b0;
        for (int unsigned k = 0; k < NUM_CLKOUT; k++) begin
            if (dec_sel == 4'(k)) decode_mx = dec_mx[k];
        end
        if (dec_sel == DEC_FB) decode_mx = fb_mx;
    end

    // Register the decoded values of the strobed target; MX!=0 holds old values.
    always_ff @(posedge DCLK or posedge RST) begin
        if (RST) begin
            out_divide   <= '{default: DIVIDE_RST};
            out_duty     <= '{default: DUTY_RST};
            out_phase    <= '{default: '0};
            out_mult     <= MULT_RST;
            out_fb_phase <= '0;
            out_divclk   <= DIVIDE_RST;
        end else if (dec_pending && !decode_mx) begin
            for (int unsigned k = 0; k < NUM_CLKOUT; k++) begin
                if (dec_sel == 4'(k)) begin
                    out_divide[k] <= dec_divide[k];
                    out_duty[k]   <= dec_duty[k];
                    out_phase[k]  <= dec_phase[k];
                end
            end
            if (dec_sel == DEC_FB) begin
                out_mult     <= fb_divide * 32'd1000;
                out_fb_phase <= fb_phase;
            end
            if (dec_sel == DEC_DIV) begin
                out_divclk <= div_reg[DIV_BYP] ? DIVIDE_RST :
                              32'(field_count(div_reg[H_HI:H_LO])) +
                              32'(field_count(div_reg[L_HI:L_LO]));
            end
        end
    end

    assign CLKFBOUT_MULT_1000  = out_mult;
    assign CLKFBOUT_PHASE_1000 = out_fb_phase;
    assign DIVCLK_DIVIDE       = out_divclk;

    // Read mux over the captured access.
    always_comb begin
        read_data = '0;
        case (acc_sel.kind)
            RK_CH: begin
                for (int unsigned k = 0; k < NUM_CLKOUT; k++) begin
                    if (32'(acc_sel.idx) == k)
                        read_data = acc_sel.second ? clk_reg2[k] : clk_reg1[k];
                end
            end
            RK_FB:  read_data = acc_sel.second ? fb_reg2 : fb_reg1;
            RK_DIV: read_data = div_reg;
            RK_LOCK: begin
                for (int unsigned k = 0; k < 3; k++) begin
                    if (32'(acc_sel.idx) == k) read_data = lock_reg[k];
                end
            end
            RK_PWR:  read_data = power_reg;
            RK_FILT: read_data = filt_reg[acc_sel.idx[0]];
            default: ;
        endcase
    end

    // Read data loads on the edge that raises DRDY; invalid reads return 0.
    always_ff @(posedge DCLK or posedge RST) begin
        if (RST)
            DO <= '0;
        else if (state == ST_BUSY && state_next == ST_ACK)
            DO <= (acc_valid && !acc_we) ? read_data : '0;
    end

    assign err_set = (DEN && !accept) || (accept && !valid_in) ||
                     (dec_pending && decode_mx);

    // Sticky error flag.
    always_ff @(posedge DCLK or posedge RST) begin
        if (RST)          ERR <= 1'b0;
        else if (err_set) ERR <= 1'b1;
    end

endmodule

// File: tb/tb_drp_reg_bank.sv
// Directed self-checking bench for drp_reg_bank: a 7-channel instance and a
// 4-channel instance for the absent-channel and busy-access cases.
module tb_drp_reg_bank;

    logic dclk = 1'b0;
    always #5 dclk = ~dclk;

    int vectors = 0;
    int miscompares = 0;

    // 7-channel instance
    logic         rst, pwrdwn, den, dwe;
    logic [6:0]   daddr;
    logic [15:0]  di;
    logic [31:0]  vco;
    logic [15:0]  dout;
    logic         drdy, err;
    logic [223:0] clk_div, clk_duty, clk_phase;
    logic [31:0]  fb_mult, fb_phase, divclk;

    // 4-channel instance
    logic         rst4, pwrdwn4, den4, dwe4;
    logic [6:0]   daddr4;
    logic [15:0]  di4;
    logic [31:0]  vco4;
    logic [15:0]  dout4;
    logic         drdy4, err4;
    logic [127:0] clk_div4, clk_duty4, clk_phase4;
    logic [31:0]  fb_mult4, fb_phase4, divclk4;

    drp_reg_bank #(.NUM_CLKOUT(7), .DRDY_LATENCY(3), .PWR_RST_VAL(16'h1111)) dut (
        .DCLK(dclk), .RST(rst), .PWRDWN(pwrdwn), .DADDR(daddr), .DEN(den), .DWE(dwe),
        .DI(di), .vco_period_1000(vco), .DO(dout), .DRDY(drdy), .ERR(err),
        .CLKOUT_DIVIDE(clk_div), .CLKOUT_DUTY_1000(clk_duty), .CLKOUT_PHASE_1000(clk_phase),
        .CLKFBOUT_MULT_1000(fb_mult), .CLKFBOUT_PHASE_1000(fb_phase), .DIVCLK_DIVIDE(divclk)
    );

    drp_reg_bank #(.NUM_CLKOUT(4), .DRDY_LATENCY(3), .PWR_RST_VAL(16'h1111)) dut4 (
        .DCLK(dclk), .RST(rst4), .PWRDWN(pwrdwn4), .DADDR(daddr4), .DEN(den4), .DWE(dwe4),
        .DI(di4), .vco_period_1000(vco4), .DO(dout4), .DRDY(drdy4), .ERR(err4),
        .CLKOUT_DIVIDE(clk_div4), .CLKOUT_DUTY_1000(clk_duty4), .CLKOUT_PHASE_1000(clk_phase4),
        .CLKFBOUT_MULT_1000(fb_mult4), .CLKFBOUT_PHASE_1000(fb_phase4), .DIVCLK_DIVIDE(divclk4)
    );

    function automatic logic [31:0] ch7(input logic [223:0] bus, input int k);
        return bus[32*k +: 32];
    endfunction

    // One complete access on the 7-channel instance; lat counts edges from
    // the accepting edge up to and including the one that raises DRDY.
    task automatic access(input logic [6:0] a, input logic we, input logic [15:0] d,
                          output logic [15:0] q, output int lat);
        @(negedge dclk);
        daddr = a; dwe = we; di = d; den = 1'b1;
        @(negedge dclk);
        den = 1'b0; dwe = 1'b0; lat = 1;
        while (!drdy && lat < 40) begin
            @(negedge dclk);
            lat++;
        end
        q = dout;
    endtask

    task automatic access4(input logic [6:0] a, input logic we, input logic [15:0] d,
                           output logic [15:0] q, output int lat);
        @(negedge dclk);
        daddr4 = a; dwe4 = we; di4 = d; den4 = 1'b1;
        @(negedge dclk);
        den4 = 1'b0; dwe4 = 1'b0; lat = 1;
        while (!drdy4 && lat < 40) begin
            @(negedge dclk);
            lat++;
        end
        q = dout4;
    endtask

    task automatic test_reset();
        rst = 1'b1; rst4 = 1'b1;
        repeat (3) @(negedge dclk);
        rst = 1'b0; rst4 = 1'b0;
        @(negedge dclk);
        vectors++;
        if ({dout, drdy, err} !== 18'h0) begin
            miscompares++;
            $display("FAIL reset_do_drdy_err: got %h/%b/%b expected 0000/0/0", dout, drdy, err);
        end
        for (int k = 0; k < 7; k++) begin
            vectors++;
            if ({ch7(clk_div, k), ch7(clk_duty, k), ch7(clk_phase, k)} !== {32'd1, 32'd500, 32'd0}) begin
                miscompares++;
                $display("FAIL reset_ch%0d: got div=%0d duty=%0d phase=%0d expected 1/500/0",
                         k, ch7(clk_div, k), ch7(clk_duty, k), ch7(clk_phase, k));
            end
        end
        vectors++;
        if ({fb_mult, fb_phase, divclk} !== {32'd1000, 32'd0, 32'd1}) begin
            miscompares++;
            $display("FAIL reset_fb_div: got mult=%0d phase=%0d divclk=%0d expected 1000/0/1",
                     fb_mult, fb_phase, divclk);
        end
    endtask

    task automatic test_read_all();
        logic [6:0]  addrs [24];
        logic [15:0] q;
        int          lat;
        addrs = '{7'h06, 7'h07, 7'h08, 7'h09, 7'h0A, 7'h0B, 7'h0C, 7'h0D, 7'h0E, 7'h0F,
                  7'h10, 7'h11, 7'h12, 7'h13, 7'h14, 7'h15, 7'h16, 7'h18, 7'h19, 7'h1A,
                  7'h28, 7'h4E, 7'h4F, 7'h28};
        foreach (addrs[i]) begin
            access(addrs[i], 1'b0, 16'h0, q, lat);
            vectors++;
            if (lat !== 3) begin
                miscompares++;
                $display("FAIL read_lat_%h: got %0d expected 3", addrs[i], lat);
            end
            vectors++;
            if (q !== ((addrs[i] == 7'h28) ? 16'h1111 : 16'h0000)) begin
                miscompares++;
                $display("FAIL read_val_%h: got %h expected %h", addrs[i], q,
                         (addrs[i] == 7'h28) ? 16'h1111 : 16'h0000);
            end
        end
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL read_all_err: got %b expected 0", err);
        end
    endtask

    task automatic test_decode_ch0();
        logic [15:0] q;
        int          lat;
        @(negedge dclk);
        daddr = 7'h08; dwe = 1'b1; di = 16'h0104; den = 1'b1;
        @(negedge dclk);
        den = 1'b0; dwe = 1'b0;
        vectors++;
        if (ch7(clk_div, 0) !== 32'd1) begin
            miscompares++;
            $display("FAIL ch0_div_before_decode: got %0d expected 1", ch7(clk_div, 0));
        end
        @(negedge dclk);
        vectors++;
        if ({ch7(clk_div, 0), ch7(clk_duty, 0)} !== {32'd8, 32'd500}) begin
            miscompares++;
            $display("FAIL ch0_decode_reg1: got div=%0d duty=%0d expected 8/500",
                     ch7(clk_div, 0), ch7(clk_duty, 0));
        end
        @(negedge dclk);
        vectors++;
        if (drdy !== 1'b1) begin
            miscompares++;
            $display("FAIL ch0_write_drdy: got %b expected 1", drdy);
        end
        access(7'h09, 1'b1, 16'h0080, q, lat);
        vectors++;
        if ({ch7(clk_div, 0), ch7(clk_duty, 0)} !== {32'd8, 32'd562}) begin
            miscompares++;
            $display("FAIL ch0_decode_edge: got div=%0d duty=%0d expected 8/562",
                     ch7(clk_div, 0), ch7(clk_duty, 0));
        end
        access(7'h08, 1'b0, 16'h0, q, lat);
        vectors++;
        if (q !== 16'h0104) begin
            miscompares++;
            $display("FAIL ch0_readback_r1: got %h expected 0104", q);
        end
        access(7'h09, 1'b0, 16'h0, q, lat);
        vectors++;
        if (q !== 16'h0080) begin
            miscompares++;
            $display("FAIL ch0_readback_r2: got %h expected 0080", q);
        end
    endtask

    task automatic test_phase_ch1();
        logic [15:0] q;
        int          lat;
        vco = 32'd1250000;
        access(7'h0A, 1'b1, 16'h6041, q, lat);
        vectors++;
        if ({ch7(clk_div, 1), ch7(clk_phase, 1)} !== {32'd2, 32'd468750}) begin
            miscompares++;
            $display("FAIL ch1_pm_phase: got div=%0d phase=%0d expected 2/468750",
                     ch7(clk_div, 1), ch7(clk_phase, 1));
        end
        access(7'h0B, 1'b1, 16'h0002, q, lat);
        vectors++;
        if (ch7(clk_phase, 1) !== 32'd2968750) begin
            miscompares++;
            $display("FAIL ch1_dt_phase: got %0d expected 2968750", ch7(clk_phase, 1));
        end
    endtask

    task automatic test_pwrdwn_abort();
        logic [15:0] q;
        int          lat;
        int          pulses;
        @(negedge dclk);
        daddr = 7'h0C; dwe = 1'b1; di = 16'h0042; den = 1'b1;
        @(negedge dclk);
        den = 1'b0; dwe = 1'b0; pwrdwn = 1'b1;
        pulses = 0;
        repeat (4) begin
            @(negedge dclk);
            if (drdy) pulses++;
        end
        vectors++;
        if (pulses !== 0) begin
            miscompares++;
            $display("FAIL pwrdwn_abort_drdy: got %0d pulses expected 0", pulses);
        end
        vectors++;
        if (ch7(clk_div, 2) !== 32'd3) begin
            miscompares++;
            $display("FAIL pwrdwn_abort_decode: got %0d expected 3", ch7(clk_div, 2));
        end
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL pwrdwn_abort_err: got %b expected 0", err);
        end
        daddr = 7'h08; den = 1'b1;
        @(negedge dclk);
        den = 1'b0;
        pulses = 0;
        repeat (4) begin
            @(negedge dclk);
            if (drdy) pulses++;
        end
        vectors++;
        if ({err, pulses[3:0]} !== 5'b1_0000) begin
            miscompares++;
            $display("FAIL den_in_pwrdwn: got err=%b pulses=%0d expected 1/0", err, pulses);
        end
        pwrdwn = 1'b0;
        access(7'h0C, 1'b0, 16'h0, q, lat);
        vectors++;
        if ({lat[7:0], q} !== {8'd3, 16'h0042}) begin
            miscompares++;
            $display("FAIL after_pwrdwn_read: got lat=%0d do=%h expected 3/0042", lat, q);
        end
    endtask

    task automatic test_rst_mid();
        logic [15:0] q;
        int          lat;
        int          pulses;
        @(negedge dclk);
        daddr = 7'h08; dwe = 1'b0; den = 1'b1;
        @(negedge dclk);
        den = 1'b0; rst = 1'b1;
        pulses = 0;
        repeat (3) begin
            @(negedge dclk);
            if (drdy) pulses++;
        end
        rst = 1'b0;
        @(negedge dclk);
        if (drdy) pulses++;
        vectors++;
        if (pulses !== 0) begin
            miscompares++;
            $display("FAIL rst_mid_drdy: got %0d pulses expected 0", pulses);
        end
        vectors++;
        if ({err, ch7(clk_div, 0), ch7(clk_phase, 1)} !== {1'b0, 32'd1, 32'd0}) begin
            miscompares++;
            $display("FAIL rst_mid_state: got err=%b div0=%0d phase1=%0d expected 0/1/0",
                     err, ch7(clk_div, 0), ch7(clk_phase, 1));
        end
        access(7'h28, 1'b0, 16'h0, q, lat);
        vectors++;
        if ({lat[7:0], q} !== {8'd3, 16'h1111}) begin
            miscompares++;
            $display("FAIL rst_mid_next_access: got lat=%0d do=%h expected 3/1111", lat, q);
        end
        access(7'h08, 1'b0, 16'h0, q, lat);
        vectors++;
        if (q !== 16'h0000) begin
            miscompares++;
            $display("FAIL rst_mid_reg_clear: got %h expected 0000", q);
        end
    endtask

    task automatic test_fb_div();
        logic [15:0] q;
        int          lat;
        access(7'h14, 1'b1, 16'h0083, q, lat);
        vectors++;
        if ({err, fb_mult} !== {1'b0, 32'd5000}) begin
            miscompares++;
            $display("FAIL fb_mult: got err=%b mult=%0d expected 0/5000", err, fb_mult);
        end
        access(7'h15, 1'b1, 16'h0100, q, lat);
        vectors++;
        if ({err, fb_mult} !== {1'b1, 32'd5000}) begin
            miscompares++;
            $display("FAIL fb_mx_err: got err=%b mult=%0d expected 1/5000", err, fb_mult);
        end
        access(7'h16, 1'b1, 16'h0083, q, lat);
        vectors++;
        if (divclk !== 32'd5) begin
            miscompares++;
            $display("FAIL divclk_count: got %0d expected 5", divclk);
        end
        access(7'h16, 1'b1, 16'h1083, q, lat);
        vectors++;
        if (divclk !== 32'd1) begin
            miscompares++;
            $display("FAIL divclk_bypass: got %0d expected 1", divclk);
        end
        access(7'h09, 1'b1, 16'h0080, q, lat);
        access(7'h08, 1'b1, 16'h0000, q, lat);
        vectors++;
        if ({ch7(clk_div, 0), ch7(clk_duty, 0)} !== {32'd128, 32'd503}) begin
            miscompares++;
            $display("FAIL ch0_hl_zero: got div=%0d duty=%0d expected 128/503",
                     ch7(clk_div, 0), ch7(clk_duty, 0));
        end
    endtask

    task automatic test_num_clkout4();
        logic [15:0] q;
        int          lat;
        int          pulses;
        vectors++;
        if (err4 !== 1'b0) begin
            miscompares++;
            $display("FAIL nc4_err_initial: got %b expected 0", err4);
        end
        @(negedge dclk);
        daddr4 = 7'h08; dwe4 = 1'b1; di4 = 16'h1234; den4 = 1'b1;
        @(negedge dclk);
        pulses = 0;
        daddr4 = 7'h0A; di4 = 16'hFFFF;
        @(negedge dclk);
        den4 = 1'b0; dwe4 = 1'b0;
        repeat (7) begin
            @(negedge dclk);
            if (drdy4) pulses++;
        end
        vectors++;
        if ({err4, pulses[3:0]} !== 5'b1_0001) begin
            miscompares++;
            $display("FAIL nc4_busy_den: got err=%b pulses=%0d expected 1/1", err4, pulses);
        end
        access4(7'h0A, 1'b0, 16'h0, q, lat);
        vectors++;
        if (q !== 16'h0000) begin
            miscompares++;
            $display("FAIL nc4_busy_write_ignored: got %h expected 0000", q);
        end
        access4(7'h08, 1'b0, 16'h0, q, lat);
        vectors++;
        if (q !== 16'h1234) begin
            miscompares++;
            $display("FAIL nc4_inflight_write: got %h expected 1234", q);
        end
        @(negedge dclk);
        rst4 = 1'b1;
        @(negedge dclk);
        rst4 = 1'b0;
        vectors++;
        if (err4 !== 1'b0) begin
            miscompares++;
            $display("FAIL nc4_err_cleared: got %b expected 0", err4);
        end
        access4(7'h12, 1'b1, 16'h0104, q, lat);
        vectors++;
        if ({lat[7:0], err4} !== {8'd3, 1'b1}) begin
            miscompares++;
            $display("FAIL nc4_invalid_write: got lat=%0d err=%b expected 3/1", lat, err4);
        end
        access4(7'h12, 1'b0, 16'h0, q, lat);
        vectors++;
        if ({lat[7:0], q} !== {8'd3, 16'h0000}) begin
            miscompares++;
            $display("FAIL nc4_invalid_read: got lat=%0d do=%h expected 3/0000", lat, q);
        end
        vectors++;
        if (clk_div4 !== {4{32'd1}}) begin
            miscompares++;
            $display("FAIL nc4_outputs_untouched: got %h expected all channels 1", clk_div4);
        end
    endtask

    initial begin
        rst = 1'b1; pwrdwn = 1'b0; den = 1'b0; dwe = 1'b0; daddr = '0; di = '0; vco = '0;
        rst4 = 1'b1; pwrdwn4 = 1'b0; den4 = 1'b0; dwe4 = 1'b0; daddr4 = '0; di4 = '0; vco4 = '0;
        test_reset();
        test_read_all();
        test_decode_ch0();
        test_phase_ch1();
        test_pwrdwn_abort();
        test_rst_mid();
        test_fb_div();
        test_num_clkout4();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
